// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP multiply-accumulate feeder.
// Contents: default operand/counter/accumulator widths and the FSM state encoding.
package dsp_pkg;

    localparam int unsigned DEF_WIDTH = 18;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_ACC_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dsp_pipe_stage.sv
// Generic pipeline register with synchronous active-high reset and load enable.
// Ports:
//   clk - clock (rising edge)
//   rst - synchronous reset, clears q
//   en  - load enable
//   d   - next value
//   q   - registered value
module dsp_pipe_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_mac_feeder.sv
// Burst multiply-accumulate feeder: accepts len signed operand pairs, runs them
// through a 3-stage register/multiply/accumulate pipeline and presents the sum
// of products with a valid/ready handshake.
// Configuration macro: DSP_MAC_SATURATE_EN -- saturating accumulator with a
// sticky overflow flag; when undefined the accumulator wraps and out_ovf is 0.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, len          - burst start request and number of operand pairs
//   in_valid, in_ready  - operand handshake; in_a/in_b signed operands
//   out_valid, out_ready- result handshake; out_p sum, out_ovf overflow flag
//   busy                - high whenever the FSM is not idle
module dsp_mac_feeder
    import dsp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_p,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_c;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_p_q, out_p_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;

    logic               beat_c;
    logic               acc_clr_c;
    logic [PROD_W-1:0]  ab_q;
    logic               v1_q, v2_q;
    logic signed [WIDTH-1:0]  a_s, b_s;
    logic signed [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0]  prod_q;
    logic [ACC_W-1:0]   prod_ext_c, sum_c, acc_nxt_c, acc_d, acc_q;
`ifdef DSP_MAC_SATURATE_EN
    logic               ovf_c;
`endif

    assign beat_c = (state_q == ST_RUN) && in_ready_q && in_valid;

    // Stage 1: capture the operand pair on an accepted beat
    dsp_pipe_stage #(.W(PROD_W)) u_s1 (
        .clk(clk), .rst(rst), .en(beat_c), .d({in_a, in_b}), .q(ab_q)
    );
    dsp_pipe_stage #(.W(1)) u_v1 (
        .clk(clk), .rst(rst), .en(1'b1), .d(beat_c), .q(v1_q)
    );

    // Stage 2: signed product
    assign a_s    = $signed(ab_q[PROD_W-1:WIDTH]);
    assign b_s    = $signed(ab_q[WIDTH-1:0]);
    assign prod_d = PROD_W'(a_s) * PROD_W'(b_s);

    dsp_pipe_stage #(.W(PROD_W)) u_s2 (
        .clk(clk), .rst(rst), .en(v1_q), .d(prod_d), .q(prod_q)
    );
    dsp_pipe_stage #(.W(1)) u_v2 (
        .clk(clk), .rst(rst), .en(1'b1), .d(v1_q), .q(v2_q)
    );

    // Stage 3: accumulate, clamping on signed overflow when saturation is built in
    always_comb begin
        prod_ext_c = {{EXT_W{prod_q[PROD_W-1]}}, prod_q};
        sum_c      = acc_q + prod_ext_c;
`ifdef DSP_MAC_SATURATE_EN
        ovf_c = (acc_q[ACC_W-1] == prod_ext_c[ACC_W-1]) &&
                (sum_c[ACC_W-1] != acc_q[ACC_W-1]);
        if (ovf_c) begin
            acc_nxt_c = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_nxt_c = sum_c;
        end
`else
        acc_nxt_c = sum_c;
`endif
        acc_d = acc_clr_c ? '0 : acc_nxt_c;
    end

    dsp_pipe_stage #(.W(ACC_W)) u_s3 (
        .clk(clk), .rst(rst), .en(v2_q | acc_clr_c), .d(acc_d), .q(acc_q)
    );

    // Burst control FSM next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        ovf_d       = ovf_q;
        acc_clr_c   = 1'b0;
        cnt_inc_c   = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        len_d      = len;
                        cnt_d      = '0;
                        acc_clr_c  = 1'b1;
                        in_ready_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        out_p_d     = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (beat_c) begin
                    cnt_d = cnt_inc_c;
                    // equality compare lets len = all-ones run without wrap
                    if (cnt_inc_c == len_q) begin
                        in_ready_d = 1'b0;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!v1_q && !v2_q) begin
                    out_p_d     = acc_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef DSP_MAC_SATURATE_EN
        if (v2_q && ovf_c) begin
            ovf_d = 1'b1;
        end
`else
        ovf_d = 1'b0;
`endif
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dsp_mac_feeder.sv
// Directed self-checking bench for dsp_mac_feeder: a default-width instance for
// the burst/handshake/reset scenarios and an ACC_W=37 instance for the
// overflow scenario (expectation follows DSP_MAC_SATURATE_EN).
module tb_dsp_mac_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_p;
    logic        out_ovf;
    logic        busy;

    logic        m_start;
    logic [7:0]  m_len;
    logic        m_in_valid;
    logic        m_in_ready;
    logic [17:0] m_in_a, m_in_b;
    logic        m_out_valid;
    logic        m_out_ready;
    logic [36:0] m_out_p;
    logic        m_out_ovf;
    logic        m_busy;

    int n_checks = 0;
    int n_errors = 0;

    dsp_mac_feeder #(.WIDTH(18), .CNT_W(8), .ACC_W(48)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_ovf(out_ovf), .busy(busy)
    );

    dsp_mac_feeder #(.WIDTH(18), .CNT_W(8), .ACC_W(37)) u_dut37 (
        .clk(clk), .rst(rst), .start(m_start), .len(m_len),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_a(m_in_a), .in_b(m_in_b),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_p(m_out_p),
        .out_ovf(m_out_ovf), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] p48(input longint v);
        return v[47:0];
    endfunction

    function automatic logic [36:0] p37(input longint v);
        return v[36:0];
    endfunction

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = 8'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input int a, input int b);
        in_valid = 1'b1;
        in_a     = 18'(a);
        in_b     = 18'(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(out_valid), 64'd1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b0;
        m_start = 1'b0; m_len = '0; m_in_valid = 1'b0; m_in_a = '0; m_in_b = '0;
        m_out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_p", 64'(out_p), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);

        // back-to-back burst, latency of three edges after the last beat
        do_start(3);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        beat(2, 3);
        beat(-4, 5);
        beat(7, -1);
        chk("t1_drain_ready", 64'(in_ready), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("t1_lat%0d", k), 64'(out_valid), (k == 3) ? 64'd1 : 64'd0);
        end
        chk("t1_out_p", 64'(out_p), 64'(p48(-21)));
        chk("t1_ovf", 64'(out_ovf), 64'd0);
        accept();
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // stalled burst with a 4-cycle gap between beats
        do_start(2);
        beat(100, 100);
        for (int k = 0; k < 4; k++) tick();
        chk("t2_ready_gap", 64'(in_ready), 64'd1);
        beat(1, 1);
        wait_done("t2");
        chk("t2_out_p", 64'(out_p), 64'(p48(10001)));
        accept();

        // zero-length burst
        do_start(0);
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_out_p", 64'(out_p), 64'd0);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        chk("t3_busy", 64'(busy), 64'd1);
        accept();
        chk("t3_idle", 64'(busy), 64'd0);

        // backpressure in DONE, start ignored there
        do_start(1);
        beat(5, 6);
        wait_done("t4");
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            len   = 8'd2;
            tick();
            chk($sformatf("t4_hold_p%0d", k), 64'(out_p), 64'(p48(30)));
            chk($sformatf("t4_hold_v%0d", k), 64'(out_valid), 64'd1);
        end
        chk("t4_no_restart", 64'(in_ready), 64'd0);
        start = 1'b1; len = 8'd3; out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("t4_acc_valid", 64'(out_valid), 64'd0);
        chk("t4_acc_busy", 64'(busy), 64'd0);
        tick();
        chk("t4_start_ignored", 64'(busy), 64'd0);

        // reset mid-burst discards everything; start in the same cycle is lost
        do_start(4);
        beat(1, 1);
        beat(2, 2);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("t5_in_ready", 64'(in_ready), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_out_p", 64'(out_p), 64'd0);
        chk("t5_out_ovf", 64'(out_ovf), 64'd0);
        tick();
        chk("t5_busy_after", 64'(busy), 64'd0);
        do_start(1);
        beat(3, 3);
        wait_done("t5");
        chk("t5_new_p", 64'(out_p), 64'(p48(9)));
        accept();

        // 255 beats of (-2^17)^2 into a 37-bit accumulator
        m_start = 1'b1; m_len = 8'd255;
        tick();
        m_start = 1'b0;
        m_in_a = 18'h20000; m_in_b = 18'h20000;
        m_in_valid = 1'b1;
        for (int k = 0; k < 255; k++) tick();
        m_in_valid = 1'b0;
        begin
            int n = 0;
            while (!m_out_valid && n < 50) begin
                tick();
                n++;
            end
        end
        chk("t6_done", 64'(m_out_valid), 64'd1);
`ifdef DSP_MAC_SATURATE_EN
        chk("t6_out_p", 64'(m_out_p), 64'(p37(64'sd68719476735)));
        chk("t6_ovf", 64'(m_out_ovf), 64'd1);
`else
        chk("t6_out_p", 64'(m_out_p), 64'(p37(-64'sd17179869184)));
        chk("t6_ovf", 64'(m_out_ovf), 64'd0);
`endif
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;
        chk("t6_idle", 64'(m_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
